// File: rtl/dg0045_rom_server.sv
// Program-ROM responder for the DG0045 instruction-fetch interface: tracks the core's
// 8-phase divider, rebuilds the PC from PC_HL, serves the byte. Optional clear: ROM_CLEAR_EN.
module dg0045_rom_server #(
   parameter int          DEPTH = 1024,
   parameter logic [7:0]  FILL  = 8'h00
) (
   input  logic        clk_in,
   input  logic        RESET,
   input  logic [4:0]  pc_hl,
   output logic        pc_mux,
   output logic [7:0]  rom_data,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [9:0]  wr_addr,
   input  logic [7:0]  wr_data,
   output logic [9:0]  fetch_pc,
   output logic        fetch_strobe
);

   localparam int          AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam logic [10:0] DEPTH_L = 11'(DEPTH);

   logic [2:0] phase_q, phase_d;
   logic [4:0] hi_q, hi_d;
   logic [7:0] rom_q, rom_d;
   logic [9:0] fetch_pc_q, fetch_pc_d;
   logic       strobe_q, strobe_d;

   logic [7:0] mem [0:(1 << AW) - 1];

   logic          clr_busy;
   logic [AW-1:0] clr_addr;

`ifdef ROM_CLEAR_EN
   localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

   logic          clr_busy_q, clr_busy_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;

   always_ff @(posedge clk_in or negedge RESET) begin
      if (!RESET) begin
         clr_busy_q <= 1'b1;
         clr_addr_q <= '0;
      end else begin
         clr_busy_q <= clr_busy_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      clr_busy_d = clr_busy_q;
      clr_addr_d = clr_addr_q;
      if (clr_busy_q) begin
         clr_addr_d = clr_addr_q + 1'b1;
         if (clr_addr_q == CLR_LAST) clr_busy_d = 1'b0;
      end
   end

   assign clr_busy = clr_busy_q;
   assign clr_addr = clr_addr_q;
`else
   assign clr_busy = 1'b0;
   assign clr_addr = '0;
`endif

   // PC bits map straight onto the array: the image is stored in PC-sequence order
   logic [9:0] pc_full;
   logic       rd_in_range;
   logic [7:0] rd_byte;
   logic       fetch_now;

   assign pc_full     = {hi_q, pc_hl};
   assign rd_in_range = ({1'b0, pc_full} < DEPTH_L);
   assign rd_byte     = rd_in_range ? mem[pc_full[AW-1:0]] : 8'h00;
   assign fetch_now   = (phase_q == 3'd3) && !clr_busy;

   // Writes are refused in phase 3 so the combinational read is never disturbed
   logic          wr_accept;
   logic          wr_in_range;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [7:0]    mem_wdata;

   assign wr_ready    = RESET && !clr_busy && (phase_q != 3'd3);
   assign wr_accept   = wr_valid && wr_ready;
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
   assign mem_we      = (clr_busy && RESET) || (wr_accept && wr_in_range);
   assign mem_waddr   = clr_busy ? clr_addr : wr_addr[AW-1:0];
   assign mem_wdata   = clr_busy ? FILL : wr_data;

   always_ff @(posedge clk_in) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_ff @(posedge clk_in or negedge RESET) begin
      if (!RESET) begin
         phase_q    <= 3'd0;
         hi_q       <= 5'd0;
         rom_q      <= 8'h00;
         fetch_pc_q <= 10'd0;
         strobe_q   <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         hi_q       <= hi_d;
         rom_q      <= rom_d;
         fetch_pc_q <= fetch_pc_d;
         strobe_q   <= strobe_d;
      end
   end

   always_comb begin
      phase_d    = phase_q + 3'd1;
      hi_d       = hi_q;
      rom_d      = rom_q;
      fetch_pc_d = fetch_pc_q;
      strobe_d   = 1'b0;
      if (phase_q == 3'd2) hi_d = pc_hl;
      if (fetch_now) begin
         rom_d      = rd_byte;
         fetch_pc_d = pc_full;
         strobe_d   = 1'b1;
      end
   end

   assign pc_mux       = (phase_q == 3'd2);
   assign rom_data     = fetch_now ? rd_byte : rom_q;
   assign fetch_pc     = fetch_pc_q;
   assign fetch_strobe = strobe_q;

endmodule
